// File: rtl/fp_divsqrt_arb_pkg.sv
// Shared types and helpers for the div/sqrt request arbiter.
package fp_divsqrt_arb_pkg;

  // Arbiter FSM: IDLE accepts a new request, BUSY waits for the unit's result.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of the core index tag; never narrower than one bit.
  function automatic int log_cores(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Response record for the default configuration (32b data, 5b fflags, 9b ID).
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  flags;
    logic [8:0]  id;
  } arb_resp_t;

endpackage

// File: rtl/fp_divsqrt_shared_arbiter_rr_arb_onehot.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module rr_arb_onehot #(
  parameter int NB_CORES  = 4,
  parameter int LOG_CORES = 2
) (
  input  logic [NB_CORES-1:0]  req,
  input  logic [LOG_CORES-1:0] rr_ptr,
  output logic [NB_CORES-1:0]  gnt,
  output logic [LOG_CORES-1:0] idx,
  output logic                 any_req
);

  logic found;

  // Scan the cores starting at the pointer, wrapping modulo NB_CORES.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % NB_CORES]) begin
        found                                = 1'b1;
        gnt[(int'(rr_ptr) + i) % NB_CORES]   = 1'b1;
        idx = LOG_CORES'((int'(rr_ptr) + i) % NB_CORES);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fp_divsqrt_shared_arbiter.sv
// Shares one iterative div/sqrt unit among NB_CORES APU requesters.
// Round-robin request arbitration, winner index tagged onto the unit ID,
// registered one-cycle response return path.
// Optional performance counters: define FP_DIVSQRT_ARB_PERF_EN.
module fp_divsqrt_shared_arbiter
  import fp_divsqrt_arb_pkg::*;
#(
  parameter int  NB_CORES        = 4,
  parameter int  ID_WIDTH        = 9,
  parameter int  NB_ARGS         = 2,
  parameter int  DATA_WIDTH      = 32,
  parameter int  OPCODE_WIDTH    = 1,
  parameter int  FLAGS_IN_WIDTH  = 5,
  parameter int  FLAGS_OUT_WIDTH = 5,
  localparam int LOG_CORES       = log_cores(NB_CORES)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NB_CORES-1:0]                      core_req_i,
  output logic [NB_CORES-1:0]                      core_gnt_o,
  input  logic [NB_CORES*ID_WIDTH-1:0]             core_ID_i,
  input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
  input  logic [NB_CORES*OPCODE_WIDTH-1:0]         core_op_i,
  input  logic [NB_CORES*FLAGS_IN_WIDTH-1:0]       core_flags_i,
  output logic [NB_CORES-1:0]                      core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]               core_rflags_o,
  output logic [ID_WIDTH-1:0]                      core_rID_o,
  output logic                                     unit_req_o,
  input  logic                                     unit_gnt_i,
  output logic [ID_WIDTH+LOG_CORES-1:0]            unit_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0]            unit_operands_o,
  output logic [OPCODE_WIDTH-1:0]                  unit_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]                unit_flags_o,
  input  logic                                     unit_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    unit_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]               unit_rflags_i,
  input  logic [ID_WIDTH+LOG_CORES-1:0]            unit_rID_i
`ifdef FP_DIVSQRT_ARB_PERF_EN
  ,
  output logic [31:0]                              perf_busy_cnt_o,
  output logic [31:0]                              perf_stall_cnt_o,
  input  logic                                     perf_clr_i
`endif
);

  localparam int OPS_W = NB_ARGS * DATA_WIDTH;
  localparam int TAG_W = ID_WIDTH + LOG_CORES;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      data;
    logic [FLAGS_OUT_WIDTH-1:0] flags;
    logic [ID_WIDTH-1:0]        id;
  } resp_t;

  arb_state_e           state_reg;
  logic [LOG_CORES-1:0] rr_ptr_reg;
  logic [LOG_CORES-1:0] rr_ptr_next;
  logic [NB_CORES-1:0]  arb_gnt;
  logic [LOG_CORES-1:0] arb_idx;
  logic                 arb_any;
  logic                 idle;
  logic                 handshake;
  logic [LOG_CORES-1:0] rtag;
  logic [NB_CORES-1:0]  rvalid_reg;
  logic [NB_CORES-1:0]  rvalid_next;
  resp_t                resp_reg;

  rr_arb_onehot #(
    .NB_CORES  (NB_CORES),
    .LOG_CORES (LOG_CORES)
  ) u_rr_arb (
    .req     (core_req_i),
    .rr_ptr  (rr_ptr_reg),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  assign idle        = (state_reg == IDLE);
  assign unit_req_o  = idle & arb_any;
  assign handshake   = unit_req_o & unit_gnt_i;
  assign rr_ptr_next = (int'(arb_idx) == NB_CORES - 1) ? '0 : arb_idx + LOG_CORES'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NB_CORES; gi++) begin : g_core
      // Grant only the current winner, and only while the unit is free.
      assign core_gnt_o[gi]  = idle & arb_gnt[gi] & unit_gnt_i;
      // Tags that name no core (>= NB_CORES) match no bit here.
      assign rvalid_next[gi] = unit_rvalid_i & (rtag == LOG_CORES'(gi));
    end
  endgenerate

  // Unit payload follows the winner; held at zero when nothing is offered.
  always_comb begin
    unit_ID_o       = '0;
    unit_operands_o = '0;
    unit_op_o       = '0;
    unit_flags_o    = '0;
    if (unit_req_o) begin
      unit_ID_o       = {arb_idx, core_ID_i[int'(arb_idx)*ID_WIDTH +: ID_WIDTH]};
      unit_operands_o = core_operands_i[int'(arb_idx)*OPS_W +: OPS_W];
      unit_op_o       = core_op_i[int'(arb_idx)*OPCODE_WIDTH +: OPCODE_WIDTH];
      unit_flags_o    = core_flags_i[int'(arb_idx)*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];
    end
  end

  // FSM: one operation in flight; pointer advances past the winner on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            state_reg  <= BUSY;
            rr_ptr_reg <= rr_ptr_next;
          end
        end
        BUSY: begin
          if (unit_rvalid_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rtag = unit_rID_i[TAG_W-1:ID_WIDTH];

  // Response return: one-cycle valid pulse, payload held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg <= '0;
      resp_reg   <= '0;
    end else begin
      rvalid_reg <= rvalid_next;
      if (unit_rvalid_i) begin
        resp_reg <= '{data: unit_rdata_i, flags: unit_rflags_i, id: unit_rID_i[ID_WIDTH-1:0]};
      end
    end
  end

  assign core_rvalid_o = rvalid_reg;
  assign core_rdata_o  = resp_reg.data;
  assign core_rflags_o = resp_reg.flags;
  assign core_rID_o    = resp_reg.id;

`ifdef FP_DIVSQRT_ARB_PERF_EN
  logic [31:0] busy_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic        stall;

  assign stall = |(core_req_i & ~core_gnt_o);

  // Saturating busy/stall counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else if (perf_clr_i) begin
      busy_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (!idle && (busy_cnt_reg != '1)) busy_cnt_reg <= busy_cnt_reg + 32'd1;
      if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_busy_cnt_o  = busy_cnt_reg;
  assign perf_stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fp_divsqrt_shared_arbiter.sv
// Self-checking bench for fp_divsqrt_shared_arbiter; the bench plays the div/sqrt unit.
// Covers FP_DIVSQRT_ARB_PERF_EN counters when that macro is defined.
module tb_fp_divsqrt_shared_arbiter;

  localparam int NB = 4, IDW = 9, DW = 32, FIW = 5, FOW = 5, TW = 11, OPSW = 64;

  logic            clk;
  logic            rst_n;
  logic [NB-1:0]   core_req_i;
  logic [NB-1:0]   core_gnt_o;
  logic [NB*IDW-1:0]  core_ID_i;
  logic [NB*OPSW-1:0] core_operands_i;
  logic [NB-1:0]   core_op_i;
  logic [NB*FIW-1:0]  core_flags_i;
  logic [NB-1:0]   core_rvalid_o;
  logic [DW-1:0]   core_rdata_o;
  logic [FOW-1:0]  core_rflags_o;
  logic [IDW-1:0]  core_rID_o;
  logic            unit_req_o;
  logic            unit_gnt_i;
  logic [TW-1:0]   unit_ID_o;
  logic [OPSW-1:0] unit_operands_o;
  logic [0:0]      unit_op_o;
  logic [FIW-1:0]  unit_flags_o;
  logic            unit_rvalid_i;
  logic [DW-1:0]   unit_rdata_i;
  logic [FOW-1:0]  unit_rflags_i;
  logic [TW-1:0]   unit_rID_i;
`ifdef FP_DIVSQRT_ARB_PERF_EN
  logic [31:0]     perf_busy_cnt_o;
  logic [31:0]     perf_stall_cnt_o;
  logic            perf_clr_i;
`endif

  fp_divsqrt_shared_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_ID_i       (core_ID_i),
    .core_operands_i (core_operands_i),
    .core_op_i       (core_op_i),
    .core_flags_i    (core_flags_i),
    .core_rvalid_o   (core_rvalid_o),
    .core_rdata_o    (core_rdata_o),
    .core_rflags_o   (core_rflags_o),
    .core_rID_o      (core_rID_o),
    .unit_req_o      (unit_req_o),
    .unit_gnt_i      (unit_gnt_i),
    .unit_ID_o       (unit_ID_o),
    .unit_operands_o (unit_operands_o),
    .unit_op_o       (unit_op_o),
    .unit_flags_o    (unit_flags_o),
    .unit_rvalid_i   (unit_rvalid_i),
    .unit_rdata_i    (unit_rdata_i),
    .unit_rflags_i   (unit_rflags_i),
    .unit_rID_i      (unit_rID_i)
`ifdef FP_DIVSQRT_ARB_PERF_EN
    ,
    .perf_busy_cnt_o  (perf_busy_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_clr_i       (perf_clr_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;  // reference round-robin pointer

  logic [IDW-1:0]  id_m  [NB];
  logic [OPSW-1:0] ops_m [NB];
  logic            op_m  [NB];
  logic [FIW-1:0]  fl_m  [NB];

  // Give core c a fresh random payload and record it for the model.
  task automatic set_payload(input int c);
    id_m[c]  = IDW'($urandom);
    ops_m[c] = {$urandom, $urandom};
    op_m[c]  = 1'($urandom);
    fl_m[c]  = FIW'($urandom);
    core_ID_i[c*IDW +: IDW]         = id_m[c];
    core_operands_i[c*OPSW +: OPSW] = ops_m[c];
    core_op_i[c]                    = op_m[c];
    core_flags_i[c*FIW +: FIW]      = fl_m[c];
  endtask

  // Reference rule: first requesting core at or after the pointer, wrapping.
  function automatic int winner(input logic [NB-1:0] mask);
    for (int k = 0; k < NB; k++)
      if (mask[(ptr_m + k) % NB]) return (ptr_m + k) % NB;
    return -1;
  endfunction

  // Unit emulation: one-cycle result pulse starting now, ends on next negedge.
  task automatic respond(input int tag, input logic [IDW-1:0] id,
                         input logic [DW-1:0] d, input logic [FOW-1:0] f);
    unit_rvalid_i = 1'b1;
    unit_rID_i    = {2'(tag), id};
    unit_rdata_i  = d;
    unit_rflags_i = f;
    @(negedge clk);
    unit_rvalid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; core_req_i = '0; unit_gnt_i = 1'b0; unit_rvalid_i = 1'b0;
    unit_rID_i = '0; unit_rdata_i = '0; unit_rflags_i = '0;
    core_ID_i = '0; core_operands_i = '0; core_op_i = '0; core_flags_i = '0;
`ifdef FP_DIVSQRT_ARB_PERF_EN
    perf_clr_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (unit_req_o !== 1'b0) begin n_err++; $display("FAIL reset_unit_req: got %b want 0", unit_req_o); end
    n_cmp++; if (core_gnt_o !== 4'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", core_gnt_o); end
    n_cmp++; if (core_rvalid_o !== 4'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0000", core_rvalid_o); end
    n_cmp++; if ({core_rdata_o, core_rflags_o, core_rID_o, unit_ID_o} !== '0) begin n_err++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", core_rdata_o, core_rflags_o, core_rID_o, unit_ID_o); end
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    $display("reset released");
  endtask

  // All cores request continuously: order 0,1,2,3,0 from a fresh reset.
  task automatic test_round_robin;
    int w;
    logic [DW-1:0] d;
    for (int c = 0; c < NB; c++) set_payload(c);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      core_req_i = 4'hF; unit_gnt_i = 1'b1;
      #1;
      w = k % NB;
      n_cmp++; if (core_gnt_o !== (4'b1 << w)) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want core %0d", k, core_gnt_o, w); end
      n_cmp++; if (unit_ID_o !== {2'(w), id_m[w]}) begin n_err++; $display("FAIL rr_unit_id[%0d]: got %h want %h", k, unit_ID_o, {2'(w), id_m[w]}); end
      $display("rr txn %0d: core %0d granted", k, w);
      @(posedge clk);
      ptr_m = (w + 1) % NB;
      @(negedge clk);
      unit_gnt_i = 1'b0;
      #1;
      n_cmp++; if (core_gnt_o !== 4'b0 || unit_req_o !== 1'b0) begin n_err++; $display("FAIL rr_busy[%0d]: gnt %b req %b want 0000 0", k, core_gnt_o, unit_req_o); end
      d = $urandom;
      respond(w, id_m[w], d, 5'h0);
      #1;
      n_cmp++; if (core_rvalid_o !== (4'b1 << w) || core_rdata_o !== d) begin n_err++; $display("FAIL rr_resp[%0d]: rvalid %b data %h want core %0d %h", k, core_rvalid_o, core_rdata_o, w, d); end
    end
    core_req_i = '0;
  endtask

  // Core 2 issues sqrt(4.0) twice; the unit returns 2.0.
  task automatic test_sqrt_single;
    logic [IDW-1:0] id;
    logic [FOW-1:0] f;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_payload(2);
      id = id_m[2];
      core_operands_i[2*OPSW +: OPSW] = {32'h0, 32'h4080_0000};
      core_op_i[2] = 1'b1;
      core_req_i = 4'b0100; unit_gnt_i = 1'b0;
      #1;
      n_cmp++; if (unit_req_o !== 1'b1 || core_gnt_o !== 4'b0) begin n_err++; $display("FAIL sqrt_pre_gnt: req %b gnt %b want 1 0000", unit_req_o, core_gnt_o); end
      n_cmp++; if (unit_ID_o !== {2'd2, id} || unit_op_o !== 1'b1 || unit_operands_o[31:0] !== 32'h4080_0000 || unit_flags_o !== fl_m[2]) begin
        n_err++; $display("FAIL sqrt_payload: id %h op %b opa %h fl %h want %h 1 40800000 %h", unit_ID_o, unit_op_o, unit_operands_o[31:0], unit_flags_o, {2'd2, id}, fl_m[2]);
      end
      unit_gnt_i = 1'b1;
      #1;
      n_cmp++; if (core_gnt_o !== 4'b0100) begin n_err++; $display("FAIL sqrt_gnt: got %b want 0100", core_gnt_o); end
      @(posedge clk);
      ptr_m = 3;
      @(negedge clk);
      core_req_i = '0; unit_gnt_i = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      f = FOW'($urandom);
      respond(2, id, 32'h4000_0000, f);
      #1;
      n_cmp++; if (core_rvalid_o !== 4'b0100 || core_rdata_o !== 32'h4000_0000 || core_rID_o !== id || core_rflags_o !== f) begin
        n_err++; $display("FAIL sqrt_resp: rvalid %b data %h id %h fl %h want 0100 40000000 %h %h", core_rvalid_o, core_rdata_o, core_rID_o, core_rflags_o, id, f);
      end
      $display("sqrt txn %0d: core 2 id %h result %h", k, id, core_rdata_o);
      @(negedge clk);
      #1;
      n_cmp++; if (core_rvalid_o !== 4'b0 || core_rdata_o !== 32'h4000_0000 || core_rID_o !== id) begin n_err++; $display("FAIL sqrt_hold: rvalid %b data %h id %h want 0000 40000000 %h", core_rvalid_o, core_rdata_o, core_rID_o, id); end
    end
  endtask

  // Core 1 requests while core 0's op is in flight; also rvalid coincides with the request.
  task automatic test_busy_block;
    logic [DW-1:0] d;
    @(negedge clk);
    core_req_i = 4'b0001; unit_gnt_i = 1'b1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0001) begin n_err++; $display("FAIL blk_gnt0: got %b want 0001", core_gnt_o); end
    @(posedge clk);
    ptr_m = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      core_req_i = 4'b0011;
      #1;
      n_cmp++; if (core_gnt_o !== 4'b0 || unit_req_o !== 1'b0) begin n_err++; $display("FAIL blk_busy[%0d]: gnt %b req %b want 0000 0", k, core_gnt_o, unit_req_o); end
    end
    @(negedge clk);
    d = $urandom;
    unit_rvalid_i = 1'b1; unit_rID_i = {2'd0, id_m[0]}; unit_rdata_i = d; unit_rflags_i = 5'h1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0) begin n_err++; $display("FAIL blk_same_cycle: gnt %b want 0000", core_gnt_o); end
    @(negedge clk);
    unit_rvalid_i = 1'b0; core_req_i = 4'b0010;
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0001 || core_rdata_o !== d) begin n_err++; $display("FAIL blk_resp0: rvalid %b data %h want 0001 %h", core_rvalid_o, core_rdata_o, d); end
    n_cmp++; if (core_gnt_o !== 4'b0010) begin n_err++; $display("FAIL blk_gnt1: got %b want 0010", core_gnt_o); end
    $display("blk txn: core 0 done, core 1 granted");
    @(posedge clk);
    ptr_m = 2;
    @(negedge clk);
    core_req_i = '0; unit_gnt_i = 1'b0;
    d = $urandom;
    respond(1, id_m[1], d, 5'h0);
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0010 || core_rdata_o !== d) begin n_err++; $display("FAIL blk_resp1: rvalid %b data %h want 0010 %h", core_rvalid_o, core_rdata_o, d); end
  endtask

  // Core 3 withdraws before the unit grants: no grant, pointer untouched.
  task automatic test_withdraw;
    int w;
    logic [DW-1:0] d;
    @(negedge clk);
    core_req_i = 4'b1000; unit_gnt_i = 1'b0;
    #1;
    n_cmp++; if (unit_req_o !== 1'b1 || unit_ID_o[TW-1:IDW] !== 2'd3) begin n_err++; $display("FAIL wd_offer: req %b tag %0d want 1 3", unit_req_o, unit_ID_o[TW-1:IDW]); end
    @(negedge clk);
    core_req_i = 4'b0000; unit_gnt_i = 1'b1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0 || unit_req_o !== 1'b0) begin n_err++; $display("FAIL wd_gone: gnt %b req %b want 0000 0", core_gnt_o, unit_req_o); end
    @(negedge clk);
    core_req_i = 4'b0110;
    #1;
    w = winner(4'b0110);
    n_cmp++; if (core_gnt_o !== (4'b1 << w)) begin n_err++; $display("FAIL wd_next: gnt %b want core %0d", core_gnt_o, w); end
    $display("wd txn: core 3 withdrew, core %0d granted", w);
    @(posedge clk);
    ptr_m = (w + 1) % NB;
    @(negedge clk);
    core_req_i = '0; unit_gnt_i = 1'b0;
    d = $urandom;
    respond(w, id_m[w], d, 5'h3);
    #1;
    n_cmp++; if (core_rvalid_o !== (4'b1 << w)) begin n_err++; $display("FAIL wd_resp: rvalid %b want core %0d", core_rvalid_o, w); end
  endtask

  // Reset while BUSY: everything clears and core 2 wins from pointer 0.
  task automatic test_reset_mid;
    logic [DW-1:0] d;
    @(negedge clk);
    core_req_i = 4'b0001; unit_gnt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_req_i = '0; unit_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0 || core_rdata_o !== '0 || core_rID_o !== '0 || core_rflags_o !== '0) begin
      n_err++; $display("FAIL rstmid_regs: rvalid %b data %h id %h fl %h want 0", core_rvalid_o, core_rdata_o, core_rID_o, core_rflags_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    core_req_i = 4'b1100; unit_gnt_i = 1'b1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0100) begin n_err++; $display("FAIL rstmid_gnt: got %b want 0100", core_gnt_o); end
    $display("rstmid txn: core 2 granted after reset");
    @(posedge clk);
    ptr_m = 3;
    @(negedge clk);
    core_req_i = '0; unit_gnt_i = 1'b0;
    d = $urandom;
    respond(2, id_m[2], d, 5'h0);
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0100 || core_rdata_o !== d) begin n_err++; $display("FAIL rstmid_resp: rvalid %b data %h want 0100 %h", core_rvalid_o, core_rdata_o, d); end
  endtask

  // A result arriving in IDLE is still routed and does not disturb the FSM.
  task automatic test_idle_rvalid;
    logic [DW-1:0] d;
    logic [IDW-1:0] id;
    @(negedge clk);
    d = $urandom; id = IDW'($urandom);
    respond(1, id, d, 5'h1F);
    core_req_i = 4'b1000; unit_gnt_i = 1'b1;
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0010 || core_rdata_o !== d || core_rID_o !== id || core_rflags_o !== 5'h1F) begin
      n_err++; $display("FAIL idlerv_resp: rvalid %b data %h id %h fl %h want 0010 %h %h 1f", core_rvalid_o, core_rdata_o, core_rID_o, core_rflags_o, d, id);
    end
    n_cmp++; if (core_gnt_o !== (4'b1 << winner(4'b1000))) begin n_err++; $display("FAIL idlerv_state: gnt %b want 1000", core_gnt_o); end
    $display("idle rvalid txn: core 1 id %h", id);
    @(posedge clk);
    ptr_m = 0;
    @(negedge clk);
    core_req_i = '0; unit_gnt_i = 1'b0;
    d = $urandom;
    respond(3, id_m[3], d, 5'h0);
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b1000 || core_rdata_o !== d) begin n_err++; $display("FAIL idlerv_resp3: rvalid %b data %h want 1000 %h", core_rvalid_o, core_rdata_o, d); end
  endtask

  // Random request masks, withdrawals, latencies and busy-time requests.
  task automatic test_random;
    logic [NB-1:0] mask, m2;
    logic [DW-1:0] d;
    logic [FOW-1:0] f;
    int w;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      for (int c = 0; c < NB; c++) set_payload(c);
      mask = 4'($urandom_range(1, 15));
      core_req_i = mask; unit_gnt_i = 1'b0;
      #1;
      w = winner(mask);
      n_cmp++; if (unit_req_o !== 1'b1 || core_gnt_o !== 4'b0) begin n_err++; $display("FAIL rnd_offer[%0d]: req %b gnt %b want 1 0000", it, unit_req_o, core_gnt_o); end
      n_cmp++; if (unit_ID_o !== {2'(w), id_m[w]} || unit_operands_o !== ops_m[w] || unit_op_o !== op_m[w] || unit_flags_o !== fl_m[w]) begin
        n_err++; $display("FAIL rnd_payload[%0d]: id %h ops %h op %b fl %h want core %0d id %h ops %h", it, unit_ID_o, unit_operands_o, unit_op_o, unit_flags_o, w, {2'(w), id_m[w]}, ops_m[w]);
      end
      if ($urandom_range(0, 2) == 0) begin
        m2 = mask & ~(4'b1 << w);
        if (m2 != 4'b0) begin
          @(negedge clk);
          core_req_i = m2; mask = m2;
          #1;
          w = winner(mask);
          n_cmp++; if (unit_ID_o !== {2'(w), id_m[w]}) begin n_err++; $display("FAIL rnd_withdraw[%0d]: id %h want %h", it, unit_ID_o, {2'(w), id_m[w]}); end
        end
      end
      unit_gnt_i = 1'b1;
      #1;
      n_cmp++; if (core_gnt_o !== (4'b1 << w)) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b want core %0d", it, core_gnt_o, w); end
      $display("rnd txn %0d: mask %b core %0d granted id %h", it, mask, w, id_m[w]);
      @(posedge clk);
      ptr_m = (w + 1) % NB;
      for (int k = 0; k < $urandom_range(1, 6); k++) begin
        @(negedge clk);
        core_req_i = 4'($urandom); unit_gnt_i = 1'($urandom);
        #1;
        n_cmp++; if (core_gnt_o !== 4'b0 || unit_req_o !== 1'b0) begin n_err++; $display("FAIL rnd_busy[%0d]: gnt %b req %b want 0000 0", it, core_gnt_o, unit_req_o); end
      end
      @(negedge clk);
      d = $urandom; f = FOW'($urandom);
      unit_gnt_i = 1'b0;
      respond(w, id_m[w], d, f);
      #1;
      n_cmp++; if (core_rvalid_o !== (4'b1 << w) || core_rdata_o !== d || core_rflags_o !== f || core_rID_o !== id_m[w]) begin
        n_err++; $display("FAIL rnd_resp[%0d]: rvalid %b data %h fl %h id %h want core %0d %h %h %h", it, core_rvalid_o, core_rdata_o, core_rflags_o, core_rID_o, w, d, f, id_m[w]);
      end
      n_cmp++; if (unit_req_o !== (|core_req_i)) begin n_err++; $display("FAIL rnd_idle[%0d]: req %b want %b", it, unit_req_o, |core_req_i); end
      core_req_i = '0;
    end
  endtask

`ifdef FP_DIVSQRT_ARB_PERF_EN
  // 12-cycle op with core 1 stalled throughout, then clear.
  task automatic test_perf;
    @(negedge clk);
    core_req_i = '0; unit_gnt_i = 1'b0; perf_clr_i = 1'b1;
    @(negedge clk);
    perf_clr_i = 1'b0;
    #1;
    n_cmp++; if (perf_busy_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL perf_clr0: busy %0d stall %0d want 0 0", perf_busy_cnt_o, perf_stall_cnt_o); end
    core_req_i = 4'b0001; unit_gnt_i = 1'b1;
    @(posedge clk);
    ptr_m = 1;
    @(negedge clk);
    core_req_i = 4'b0010; unit_gnt_i = 1'b0;
    repeat (11) @(negedge clk);
    respond(0, id_m[0], 32'h1, 5'h0);
    core_req_i = '0;
    #1;
    n_cmp++; if (perf_busy_cnt_o !== 32'd12) begin n_err++; $display("FAIL perf_busy: got %0d want 12", perf_busy_cnt_o); end
    n_cmp++; if (perf_stall_cnt_o !== 32'd12) begin n_err++; $display("FAIL perf_stall: got %0d want 12", perf_stall_cnt_o); end
    $display("perf txn: busy %0d stall %0d", perf_busy_cnt_o, perf_stall_cnt_o);
    @(negedge clk);
    perf_clr_i = 1'b1;
    @(negedge clk);
    perf_clr_i = 1'b0;
    #1;
    n_cmp++; if (perf_busy_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL perf_clr1: busy %0d stall %0d want 0 0", perf_busy_cnt_o, perf_stall_cnt_o); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_round_robin;
    test_sqrt_single;
    test_busy_block;
    test_withdraw;
    test_reset_mid;
    test_idle_rvalid;
    test_random;
`ifdef FP_DIVSQRT_ARB_PERF_EN
    test_perf;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
